spatz_xmem_responder: RTL

Memory-side responder for the Spatz X-interface memory protocol. Sits between one VLSU memory port and one TCDM-style SRAM bank port; one instance per port.
- Accepts x_mem requests (id, addr, we, strb, wdata, last).
- Forwards them to the bank with a req/gnt handshake.
- Tracks outstanding transactions in order.
- Returns load results tagged with the original id on the result channel, which has no backpressure.

---
 rtl/spatz_xmem_responder_pkg.sv | 39 +++
 rtl/spatz_xmem_responder_fifo.sv | 69 ++++++
 rtl/spatz_xmem_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/spatz_xmem_responder_pkg.sv
// Shared types for the Spatz X-interface memory responder: x_mem request,
// response and result structs plus the index-width helper.
package spatz_xmem_responder_pkg;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int unsigned idx_width(input int unsigned num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

  localparam int unsigned NrOutstanding = 8;
  localparam int unsigned IdWidth       = idx_width(NrOutstanding);
  localparam int unsigned CntWidth      = idx_width(NrOutstanding + 1);

  typedef logic [IdWidth-1:0] id_t;

  typedef struct packed {
    id_t         id;
    logic [31:0] addr;
    logic [1:0]  mode;
    logic [1:0]  size;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        last;
    logic        spec;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
  } x_mem_resp_t;

  typedef struct packed {
    id_t         id;
    logic [31:0] rdata;
    logic        err;
  } x_mem_result_t;

endpackage

// File: rtl/spatz_xmem_responder_fifo.sv
// In-order tracking FIFO without fall-through; exposes its fill level so the
// responder can use it directly as the outstanding-transaction counter.
module spatz_xmem_responder_fifo #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_WIDTH = 4,
  parameter type         dtype_t   = logic
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  dtype_t               data_i,
  input  logic                 pop_i,
  output dtype_t               data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CNT_WIDTH-1:0] usage_o
);

  localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dtype_t                mem_q [DEPTH];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == CNT_WIDTH'(DEPTH));
  assign empty_o = (count_q == '0);
  assign usage_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full/empty are judged on the registered count, so a same-cycle pop never
  // makes room for a push.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer advance and fill-level bookkeeping; pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state clears asynchronously so reset empties the FIFO at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while the count covers them.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/spatz_xmem_responder.sv
// Memory-side responder: forwards x_mem requests to one SRAM bank port,
// tracks granted transactions in order and returns id-tagged load results.
module spatz_xmem_responder
  import spatz_xmem_responder_pkg::*;
#(
  parameter int unsigned NR_OUTSTANDING = 8,
  parameter type         x_mem_req_t    = spatz_xmem_responder_pkg::x_mem_req_t,
  parameter type         x_mem_resp_t   = spatz_xmem_responder_pkg::x_mem_resp_t,
  parameter type         x_mem_result_t = spatz_xmem_responder_pkg::x_mem_result_t,
  localparam int unsigned IdWidth       = idx_width(NR_OUTSTANDING),
  localparam int unsigned CntWidth      = idx_width(NR_OUTSTANDING + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                x_mem_valid_i,
  output logic                x_mem_ready_o,
  input  x_mem_req_t          x_mem_req_i,
  output x_mem_resp_t         x_mem_resp_o,
  output logic                x_mem_result_valid_o,
  output x_mem_result_t       x_mem_result_o,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  output logic [31:0]         mem_addr_o,
  output logic                mem_we_o,
  output logic [3:0]          mem_be_o,
  output logic [31:0]         mem_wdata_o,
  input  logic                mem_rvalid_i,
  input  logic [31:0]         mem_rdata_i,
  output logic                busy_o,
  output logic                txn_done_o,
  output logic [CntWidth-1:0] outstanding_o
);

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic               we;
    logic               last;
  } track_t;

  track_t              push_entry, head;
  logic                fifo_full, fifo_empty, pop;
  logic [CntWidth-1:0] usage;

  x_mem_result_t result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic          txn_done_q, txn_done_d;

  logic unused_req;
  assign unused_req = ^{x_mem_req_i.mode, x_mem_req_i.size, x_mem_req_i.spec,
                        x_mem_req_i.addr[1:0]};

  // Request path is purely combinational; a full tracker blocks the bank request.
  assign mem_req_o     = x_mem_valid_i & ~fifo_full;
  assign x_mem_ready_o = mem_req_o & mem_gnt_i;
  assign mem_addr_o    = {x_mem_req_i.addr[31:2], 2'b00};
  assign mem_we_o      = x_mem_req_i.we;
  assign mem_be_o      = x_mem_req_i.we ? x_mem_req_i.strb : 4'hF;
  assign mem_wdata_o   = x_mem_req_i.wdata;
  assign x_mem_resp_o  = '0;

  assign push_entry.id   = x_mem_req_i.id;
  assign push_entry.we   = x_mem_req_i.we;
  assign push_entry.last = x_mem_req_i.last;

  // Bank responses arriving with nothing tracked are dropped.
  assign pop = mem_rvalid_i & ~fifo_empty;

  spatz_xmem_responder_fifo #(
    .DEPTH     (NR_OUTSTANDING),
    .CNT_WIDTH (CntWidth),
    .dtype_t   (track_t)
  ) i_track_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (x_mem_ready_o),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (usage)
  );

  assign outstanding_o = usage;
  assign busy_o        = (usage != '0);

  // Retire the head entry: loads produce a result, stores vanish silently.
  always_comb begin
    result_d       = result_q;
    result_valid_d = 1'b0;
    txn_done_d     = 1'b0;
    if (pop) begin
      txn_done_d = head.last;
      if (!head.we) begin
        result_valid_d = 1'b1;
        result_d.id    = head.id;
        result_d.rdata = mem_rdata_i;
        result_d.err   = 1'b0;
      end
    end
  end

  // Registered result channel; it has no backpressure so every pulse is final.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
      txn_done_q     <= 1'b0;
    end else begin
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      txn_done_q     <= txn_done_d;
    end
  end

  assign x_mem_result_o       = result_q;
  assign x_mem_result_valid_o = result_valid_q;
  assign txn_done_o           = txn_done_q;

  // A bank response without a tracked transaction is ignored but reported.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   mem_rvalid_i |-> !fifo_empty)
    else $warning("[spatz_xmem_responder] stray mem_rvalid_i ignored");

  // The bank may only see a changing request once it has been granted.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   (mem_req_o && !mem_gnt_i) |=>
                   ($stable(mem_addr_o) && $stable(mem_we_o) &&
                    $stable(mem_be_o) && $stable(mem_wdata_o)))
    else $error("[spatz_xmem_responder] bank request changed while stalled");

endmodule
